// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - EX-stage ALU with start/done handshake and iterative mul/div into HI/LO
module alu_multicycle #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  src1_i,
    input  logic [WIDTH-1:0]  src2_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  result_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o,
    output logic              zero_o
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_JR    = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] OP_SLT   = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] OP_MULT  = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] OP_MULTU = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] OP_DIV   = CTRL_W'(4'b1010);
    localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(4'b1011);
    localparam logic [CTRL_W-1:0] OP_NOR   = CTRL_W'(4'b1100);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_a;        // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_acc;      // product high half / partial remainder
    logic [WIDTH-1:0] r_q;        // multiplier bits / dividend bits -> quotient
    logic             r_is_div;
    logic             r_neg_q;    // negate product or quotient at FIX
    logic             r_neg_r;    // negate remainder at FIX (dividend was negative)
    logic             r_zero_cap;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_zero;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_eq;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_is_mul   = (ctrl_i == OP_MULT) || (ctrl_i == OP_MULTU);
    assign w_is_div   = (ctrl_i == OP_DIV)  || (ctrl_i == OP_DIVU);
    assign w_signed   = (ctrl_i == OP_MULT) || (ctrl_i == OP_DIV);
    assign w_a_neg    = w_signed & src1_i[WIDTH-1];
    assign w_b_neg    = w_signed & src2_i[WIDTH-1];
    // Negating MIN yields MIN, which read as unsigned is the correct magnitude.
    assign w_a_mag    = w_a_neg ? -src1_i : src1_i;
    assign w_b_mag    = w_b_neg ? -src2_i : src2_i;
    assign w_div_zero = w_is_div && (src2_i == '0);
    assign w_eq       = (src1_i == src2_i);

    // Single-cycle ALU result from the live operands.
    always_comb begin
        w_alu = '0;
        case (ctrl_i)
            OP_AND: w_alu = src1_i & src2_i;
            OP_OR:  w_alu = src1_i | src2_i;
            OP_ADD: w_alu = src1_i + src2_i;
            OP_SUB: w_alu = src1_i - src2_i;
            OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_JR:  w_alu = src1_i;
            OP_NOR: w_alu = ~(src1_i | src2_i);
            default: w_alu = '0;
        endcase
    end

    // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
    assign w_addend = r_q[0] ? r_a : '0;
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

    // Restoring-divide step: shift in next dividend bit, subtract divisor if it fits.
    assign w_shift  = {r_acc, r_q[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_a});
    assign w_diff   = w_shift[WIDTH-1:0] - r_a;

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_q : r_q;
    assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;
    assign w_fix_hi   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_fix_lo   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

    // Control FSM and datapath registers; reset wins over a same-edge start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_a        <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero_cap <= 1'b0;
            r_result   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_div_zero) begin
                            r_lo     <= '1;
                            r_hi     <= src1_i;
                            r_result <= '1;
                            r_zero   <= w_eq;
                            r_state  <= S_DONE;
                        end else if (w_is_mul || w_is_div) begin
                            r_a        <= w_b_mag;
                            r_q        <= w_a_mag;
                            r_acc      <= '0;
                            r_is_div   <= w_is_div;
                            r_neg_q    <= w_a_neg ^ w_b_neg;
                            r_neg_r    <= w_a_neg;
                            r_zero_cap <= w_eq;
                            r_count    <= CNT_W'(WIDTH-1);
                            r_state    <= S_ITER;
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= w_eq;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_ITER: begin
                    if (r_is_div) begin
                        r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_sum[WIDTH:1];
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    end
                    if (r_count == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_FIX: begin
                    r_hi     <= w_fix_hi;
                    r_lo     <= w_fix_lo;
                    r_result <= w_fix_lo;
                    r_zero   <= r_zero_cap;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;
    assign zero_o   = r_zero;

endmodule
